ieeedrv_rom_arbiter: RTL

// - Shares one synchronous ROM (DOS or controller) among NCH drive CPUs via per-channel req/ack handshakes.
// - Round-robin arbitration, configurable ROM read latency, per-channel last-address tag:

---
 rtl/ieeedrv_rom_arbiter_if.sv | 29 ++
 rtl/ieeedrv_rom_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/ieeedrv_rom_arbiter_if.sv
// ieeedrv_rom_arbiter_if: per-channel fetch handshake plus shared ROM port of the drive ROM arbiter.
// The slave modport faces the arbiter, the master modport faces the drives and ROM.
interface ieeedrv_rom_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 14,
    parameter int DW  = 8
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              flush;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_ack;
    logic [NCH*DW-1:0] ch_data;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_q;
    logic              busy;
    logic [IW-1:0]     grant_id;

    modport slave (
        input  flush, ch_req, ch_addr, rom_q,
        output ch_ack, ch_data, rom_addr, busy, grant_id
    );

    modport master (
        output flush, ch_req, ch_addr, rom_q,
        input  ch_ack, ch_data, rom_addr, busy, grant_id
    );
endinterface

// File: rtl/ieeedrv_rom_arbiter.sv
// ieeedrv_rom_arbiter: round-robin sharing of one synchronous ROM among NCH drive CPUs,
// with a per-channel last-address tag so repeat fetches are answered without a ROM access.
module ieeedrv_rom_arbiter #(
    parameter int NCH   = 4,
    parameter int AW    = 14,
    parameter int DW    = 8,
    parameter int RDLAT = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    ieeedrv_rom_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [AW-1:0]     rom_addr_q, rom_addr_d;
    logic [NCH-1:0]    ack_q, ack_d;
    logic [NCH-1:0]    tag_vld_q, tag_vld_d;
    logic [NCH*DW-1:0] data_q, data_d;
    logic [NCH*AW-1:0] tag_q, tag_d;
    logic              flush_seen_q, flush_seen_d;
    logic [NCH-1:0]    hit, cand;
    logic              found;
    logic [IW-1:0]     sel;

    // A flush in the same cycle overrides any tag hit, turning it into a miss.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            hit[i] = bus.ch_req[i] & tag_vld_q[i] & ~bus.flush
                   & (bus.ch_addr[i*AW +: AW] == tag_q[i*AW +: AW])
                   & ~(state_q == WAIT && grant_q == IW'(i));
        end
        cand = bus.ch_req & ~hit & ~ack_q;
    end

    // Scan offsets from the pointer downwards so the smallest offset wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (cand[(int'(rr_q) + k) % NCH]) begin
                found = 1'b1;
                sel   = IW'((int'(rr_q) + k) % NCH);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        rom_addr_d   = rom_addr_q;
        ack_d        = hit;
        data_d       = data_q;
        tag_d        = tag_q;
        tag_vld_d    = bus.flush ? '0 : tag_vld_q;
        flush_seen_d = flush_seen_q;
        if (state_q == IDLE) begin
            flush_seen_d = 1'b0;
            if (found) begin
                rom_addr_d = bus.ch_addr[sel*AW +: AW];
                grant_d    = sel;
                rr_d       = IW'((int'(sel) + 1) % NCH);
                cnt_d      = 2'(RDLAT);
                state_d    = WAIT;
            end
        end else begin
            flush_seen_d = flush_seen_q | bus.flush;
            cnt_d        = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                data_d[grant_q*DW +: DW] = bus.rom_q;
                tag_d[grant_q*AW +: AW]  = rom_addr_q;
                tag_vld_d[grant_q]       = ~(flush_seen_q | bus.flush);
                ack_d[grant_q]           = 1'b1;
                state_d                  = IDLE;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_q         <= '0;
            grant_q      <= '0;
            rom_addr_q   <= '0;
            ack_q        <= '0;
            tag_vld_q    <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            rom_addr_q   <= rom_addr_d;
            ack_q        <= ack_d;
            tag_vld_q    <= tag_vld_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    assign bus.ch_ack   = ack_q;
    assign bus.ch_data  = data_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = (state_q == WAIT);
    assign bus.grant_id = grant_q;
endmodule
